// File: rtl/sio_nibble_rx_pkg.sv
// Shared types and widths for the quad-lane nibble receiver.
package sio_pkg;
  localparam int SIO_LANES = 4;
  localparam int NIBBLE_W  = 4;
  localparam int BYTE_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_TURNAROUND = 2'd1,
    ST_RECV       = 2'd2
  } sio_state_e;
endpackage

// File: rtl/sio_nibble_rx_if.sv
// Control, pad and byte-stream signals of sio_nibble_rx; slave is the receiver side.
interface sio_nibble_rx_if
  import sio_pkg::*;
#(
  parameter int DUMMY_W = 4
);
  logic [SIO_LANES-1:0] sio_i;
  logic [SIO_LANES-1:0] sio_oe;
  logic                 sample_en;
  logic                 start;
  logic                 abort;
  logic [DUMMY_W-1:0]   dummy_cycles;
  logic [7:0]           byte_count;
  logic [BYTE_W-1:0]    rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 busy;
  logic                 done;
  logic                 overflow;

  modport master (
    output sio_i, sample_en, start, abort, dummy_cycles, byte_count, rx_ready,
    input  sio_oe, rx_data, rx_valid, busy, done, overflow
  );

  modport slave (
    input  sio_i, sample_en, start, abort, dummy_cycles, byte_count, rx_ready,
    output sio_oe, rx_data, rx_valid, busy, done, overflow
  );
endinterface

// File: rtl/sio_nibble_rx_fifo.sv
// Register-based byte FIFO; a push into a full FIFO is accepted only when a pop frees a slot.
module sio_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  // Pointers are exactly log2(DEPTH) bits wide, so they wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/sio_nibble_rx.sv
// Quad-lane read receiver: skips dummy samples, packs nibble pairs into bytes, queues them.
// Define SIO_NIBBLE_RX_SYNC_EN to put a two-flop synchroniser on sio_i.
module sio_nibble_rx
  import sio_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DUMMY_W    = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  sio_nibble_rx_if.slave bus
);
  logic [1:0]          rst_sync_q;
  logic                rst_n;
  logic [NIBBLE_W-1:0] nib;
  sio_state_e          state_q;
  logic [DUMMY_W-1:0]  dummy_q;
  logic [DUMMY_W-1:0]  turn_cnt_q;
  logic [DUMMY_W-1:0]  turn_cnt_d;
  logic [8:0]          left_q;
  logic                half_q;
  logic [NIBBLE_W-1:0] hi_q;
  logic                done_q;
  logic                ovf_q;
  logic                pop;
  logic                push;
  logic                fifo_full;
  logic                fifo_empty;
  logic [BYTE_W-1:0]   fifo_rdata;

  // Assertion is immediate; release reaches the rest of the design two edges later.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  assign rst_n = rst_sync_q[1];

`ifdef SIO_NIBBLE_RX_SYNC_EN
  logic [NIBBLE_W-1:0] sio_s1_q;
  logic [NIBBLE_W-1:0] sio_s2_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sio_s1_q <= '0;
      sio_s2_q <= '0;
    end else begin
      sio_s1_q <= bus.sio_i;
      sio_s2_q <= sio_s1_q;
    end
  end
  assign nib = sio_s2_q;
`else
  assign nib = bus.sio_i;
`endif

  assign pop        = bus.rx_ready && !fifo_empty;
  assign push       = (state_q == ST_RECV) && bus.sample_en && half_q && !bus.abort;
  assign turn_cnt_d = turn_cnt_q + DUMMY_W'(1);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      dummy_q    <= '0;
      turn_cnt_q <= '0;
      left_q     <= '0;
      half_q     <= 1'b0;
      hi_q       <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.abort) begin
        state_q <= ST_IDLE;
        half_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bus.start) begin
              dummy_q    <= bus.dummy_cycles;
              turn_cnt_q <= '0;
              left_q     <= {bus.byte_count == '0, bus.byte_count};
              half_q     <= 1'b0;
              ovf_q      <= 1'b0;
              state_q    <= (bus.dummy_cycles == '0) ? ST_RECV : ST_TURNAROUND;
            end
          end
          ST_TURNAROUND: begin
            if (bus.sample_en) begin
              turn_cnt_q <= turn_cnt_d;
              if (turn_cnt_d == dummy_q) begin
                state_q <= ST_RECV;
              end
            end
          end
          ST_RECV: begin
            if (bus.sample_en) begin
              if (!half_q) begin
                hi_q   <= nib;
                half_q <= 1'b1;
              end else begin
                // A dropped byte still counts towards the transfer length.
                half_q <= 1'b0;
                left_q <= left_q - 9'd1;
                if (fifo_full && !pop) begin
                  ovf_q <= 1'b1;
                end
                if (left_q == 9'd1) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b1;
                end
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  sio_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (BYTE_W)
  ) u_fifo (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({hi_q, nib}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.rx_data  = fifo_rdata;
  assign bus.rx_valid = !fifo_empty;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.sio_oe   = '0;
endmodule

// File: tb/tb_sio_nibble_rx.sv
// Randomised bench for sio_nibble_rx against a transaction-level queue model.
`timescale 1ns/1ps
module tb_sio_nibble_rx;
  localparam int DEPTH = 4;
  localparam int DW    = 4;
`ifdef SIO_NIBBLE_RX_SYNC_EN
  localparam int SYNC = 1;
`else
  localparam int SYNC = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sio_nibble_rx_if #(.DUMMY_W(DW)) bus ();

  sio_nibble_rx #(
    .FIFO_DEPTH (DEPTH),
    .DUMMY_W    (DW)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: byte queue plus transfer bookkeeping.
  logic [7:0] mq[$];
  bit         m_active;
  int         m_pulses, m_dummy, m_total, m_nbytes;
  logic [3:0] m_hi;
  bit         m_ovf, m_done;

  logic [7:0] got[$];
  int         done_cnt;
  logic [7:0] data_arr[256];

  task automatic check_eq(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got_v, exp_v, $time);
    end
  endtask

  task automatic model_update();
    bit         pop_now;
    bit         push_now;
    logic [7:0] b;
    int         j;
    pop_now  = (mq.size() > 0) && bus.rx_ready;
    push_now = 0;
    b        = '0;
    m_done   = 0;
    if (bus.abort) begin
      m_active = 0;
    end else if (!m_active) begin
      if (bus.start) begin
        m_active = 1;
        m_pulses = 0;
        m_dummy  = int'(bus.dummy_cycles);
        m_total  = (bus.byte_count == 8'd0) ? 256 : int'(bus.byte_count);
        m_nbytes = 0;
        m_ovf    = 0;
      end
    end else if (bus.sample_en) begin
      m_pulses++;
      j = m_pulses - m_dummy - 1;
      if (j >= 0) begin
        if (j % 2 == 0) begin
          m_hi = bus.sio_i;
        end else begin
          b = {m_hi, bus.sio_i};
          if (mq.size() == DEPTH && !pop_now) m_ovf = 1;
          else push_now = 1;
          m_nbytes++;
          if (m_nbytes == m_total) begin
            m_active = 0;
            m_done   = 1;
          end
        end
      end
    end
    if (pop_now) void'(mq.pop_front());
    if (push_now) mq.push_back(b);
  endtask

  task automatic check_outputs();
    check_eq("rx_valid", bus.rx_valid, mq.size() > 0);
    if (mq.size() > 0) check_eq("rx_data", bus.rx_data, mq[0]);
    check_eq("busy", bus.busy, m_active);
    check_eq("done", bus.done, m_done);
    check_eq("overflow", bus.overflow, m_ovf);
    check_eq("sio_oe", bus.sio_oe, 0);
    if (bus.done) done_cnt++;
  endtask

  task automatic step();
    if (bus.rx_valid && bus.rx_ready) got.push_back(bus.rx_data);
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic cyc(input int ready_pct);
    bus.rx_ready = ($urandom_range(99) < ready_pct);
    step();
  endtask

  task automatic do_reset_mid();
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_rx_valid", bus.rx_valid, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_overflow", bus.overflow, 0);
    check_eq("rst_rx_data", bus.rx_data, 0);
    check_eq("rst_done", bus.done, 0);
    mq.delete();
    m_active = 0;
    m_ovf    = 0;
    m_done   = 0;
    bus.sample_en = 1'b0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) cyc(0);
  endtask

  // stop_kind: 0 none, 1 abort before pulse stop_p, 2 reset before pulse stop_p.
  task automatic xfer(input int dummy, input int cnt, input int stop_p, input int stop_kind,
                      input int ready_pct);
    int         nb;
    int         total;
    int         gap;
    int         j;
    logic [3:0] nib;
    nb    = (cnt == 0) ? 256 : cnt;
    total = dummy + 2 * nb;
    bus.start        = 1'b1;
    bus.dummy_cycles = DW'(dummy);
    bus.byte_count   = 8'(cnt);
    bus.sio_i        = 4'($urandom);
    cyc(ready_pct);
    bus.start = 1'b0;
    for (int p = 1; p <= total; p++) begin
      j = p - dummy - 1;
      if (j >= 0) nib = (j % 2 == 0) ? data_arr[j/2][7:4] : data_arr[j/2][3:0];
      else nib = 4'($urandom);
      if (p == stop_p) begin
        if (stop_kind == 1) begin
          bus.abort = 1'b1;
          bus.start = 1'($urandom_range(1));
          cyc(ready_pct);
          bus.abort = 1'b0;
          bus.start = 1'b0;
        end else begin
          do_reset_mid();
        end
        return;
      end
      gap = $urandom_range(2) + 2 * SYNC;
      for (int g = 0; g < gap; g++) begin
        bus.sio_i        = nib;
        bus.start        = ($urandom_range(7) == 0);
        bus.dummy_cycles = DW'($urandom);
        bus.byte_count   = 8'($urandom);
        cyc(ready_pct);
      end
      bus.start     = 1'b0;
      bus.sio_i     = nib;
      bus.sample_en = 1'b1;
      cyc(ready_pct);
      bus.sample_en = 1'b0;
    end
    for (int k = 0; k < 4; k++) cyc(ready_pct);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [7:0] old0;
    int         bad;
    int         dmy, cnt, stop;
    bus.sio_i = '0; bus.sample_en = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
    bus.dummy_cycles = '0; bus.byte_count = '0; bus.rx_ready = 1'b0;
    m_active = 0; m_ovf = 0; m_done = 0; m_hi = '0;
    m_pulses = 0; m_dummy = 0; m_total = 0; m_nbytes = 0;
    done_cnt = 0;

    repeat (3) @(negedge clk);
    check_eq("reset_rx_valid", bus.rx_valid, 0);
    check_eq("reset_rx_data", bus.rx_data, 0);
    check_eq("reset_busy", bus.busy, 0);
    check_eq("reset_done", bus.done, 0);
    check_eq("reset_overflow", bus.overflow, 0);
    check_eq("reset_sio_oe", bus.sio_oe, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) cyc(0);

    // Two dummy samples, then A,5,3,C.
    data_arr[0] = 8'hA5;
    data_arr[1] = 8'h3C;
    got.delete(); done_cnt = 0;
    xfer(2, 2, 0, 0, 100);
    check_eq("t1_nbytes", got.size(), 2);
    if (got.size() >= 1) check_eq("t1_byte0", got[0], 8'hA5);
    if (got.size() >= 2) check_eq("t1_byte1", got[1], 8'h3C);
    check_eq("t1_done_pulses", done_cnt, 1);
    check_eq("t1_overflow", bus.overflow, 0);
    $display("xfer t1 dummy=2 cnt=2 bytes=%0d done=%0d", got.size(), done_cnt);

    // Five bytes into a stalled four-deep FIFO.
    for (int i = 0; i < 5; i++) data_arr[i] = 8'($urandom);
    got.delete(); done_cnt = 0;
    xfer(1, 5, 0, 0, 0);
    check_eq("t2_overflow", bus.overflow, 1);
    check_eq("t2_done_pulses", done_cnt, 1);
    check_eq("t2_rx_valid", bus.rx_valid, 1);
    for (int k = 0; k < 8; k++) cyc(100);
    check_eq("t2_nbytes", got.size(), 4);
    for (int i = 0; i < 4; i++) if (got.size() > i) check_eq("t2_byte", got[i], data_arr[i]);
    $display("xfer t2 cnt=5 stalled drained=%0d", got.size());

    // byte_count 0 means 256 bytes.
    for (int i = 0; i < 256; i++) data_arr[i] = 8'($urandom);
    got.delete(); done_cnt = 0;
    xfer(3, 0, 0, 0, 100);
    check_eq("t3_nbytes", got.size(), 256);
    bad = 0;
    for (int i = 0; i < 256; i++) if (got.size() > i && got[i] !== data_arr[i]) bad++;
    check_eq("t3_data_mismatches", bad, 0);
    check_eq("t3_busy", bus.busy, 0);
    check_eq("t3_done_pulses", done_cnt, 1);
    $display("xfer t3 cnt=256 bytes=%0d", got.size());

    // Abort between the two nibbles of byte 1, then a fresh transfer.
    for (int i = 0; i < 3; i++) data_arr[i] = 8'($urandom);
    old0 = data_arr[0];
    got.delete(); done_cnt = 0;
    xfer(1, 3, 5, 1, 0);
    check_eq("t4_busy", bus.busy, 0);
    check_eq("t4_rx_valid", bus.rx_valid, 1);
    check_eq("t4_rx_data", bus.rx_data, old0);
    check_eq("t4_done_pulses", done_cnt, 0);
    for (int i = 0; i < 2; i++) data_arr[i] = 8'($urandom);
    xfer(0, 2, 0, 0, 100);
    check_eq("t4_nbytes", got.size(), 3);
    if (got.size() >= 1) check_eq("t4_first", got[0], old0);
    check_eq("t4_done_pulses_after", done_cnt, 1);
    $display("xfer t4 abort then restart bytes=%0d", got.size());

    // Randomised transfers with occasional aborts.
    for (int n = 0; n < 30; n++) begin
      dmy = $urandom_range(5);
      cnt = $urandom_range(9, 1);
      stop = ($urandom_range(5) == 0) ? $urandom_range(dmy + 2 * cnt, 1) : 0;
      for (int i = 0; i < cnt; i++) data_arr[i] = 8'($urandom);
      xfer(dmy, cnt, stop, 1, $urandom_range(100));
      $display("xfer rnd%0d dummy=%0d cnt=%0d abort_at=%0d q=%0d", n, dmy, cnt, stop, mq.size());
    end
    for (int k = 0; k < 8; k++) cyc(100);

    // Reset mid-RECV with two bytes queued.
    for (int i = 0; i < 4; i++) data_arr[i] = 8'($urandom);
    xfer(0, 4, 6, 2, 0);
    for (int i = 0; i < 2; i++) data_arr[i] = 8'($urandom);
    got.delete(); done_cnt = 0;
    xfer(1, 2, 0, 0, 100);
    check_eq("t6_nbytes", got.size(), 2);
    check_eq("t6_done_pulses", done_cnt, 1);
    $display("xfer t6 reset mid-recv then restart bytes=%0d", got.size());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sio_nibble_rx.md
SIO_NIBBLE_RX -- requirements
Module: sio_nibble_rx

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, output byte FIFO depth in entries, power of two, minimum 2.
REQ-002 Parameter DUMMY_W, default 4, width of the dummy_cycles input.
REQ-003 sys_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-005 sio_i  input  4  pad input values of sio0..sio3.
REQ-006 sio_oe  output  4  pad output enables; held 0 (released) in every state.
REQ-007 sample_en  input  1  one-cycle strobe marking an SCK sampling edge.
REQ-008 start  input  1  pulse that begins a read transfer.
REQ-009 abort  input  1  pulse that terminates a transfer.
REQ-010 dummy_cycles  input  DUMMY_W  turnaround sample count, captured on start.
REQ-011 byte_count  input  8  bytes to receive, captured on start; 0 means 256.
REQ-012 rx_data  output  8  FIFO head byte.
REQ-013 rx_valid  output  1  FIFO not empty.
REQ-014 rx_ready  input  1  consumer accept; pop when rx_valid and rx_ready are both 1.
REQ-015 busy  output  1  high in TURNAROUND and RECV.
REQ-016 done  output  1  one-cycle pulse when the last byte is pushed or dropped.
REQ-017 overflow  output  1  sticky; set when a completed byte meets a full FIFO.

Function
REQ-018 States: IDLE, TURNAROUND, RECV.
REQ-019 IDLE + start: capture inputs; go to TURNAROUND, or to RECV when dummy_cycles=0.
REQ-020 start while busy is ignored.
REQ-021 TURNAROUND: count sample_en pulses; sio_i ignored; go to RECV on the cycle after the dummy_cycles-th pulse.
REQ-022 RECV: each sample_en captures one nibble; first nibble is bits 7:4, second is bits 3:0.
REQ-023 The byte is pushed on the clock edge that samples the second nibble; rx_valid rises the following cycle.
REQ-024 Push while full: byte dropped, overflow set, and the remaining byte count still decrements.
REQ-025 Simultaneous push and pop on a full FIFO is accepted and is not an overflow.
REQ-026 Last byte pushed or dropped: done pulses the next cycle and the state returns to IDLE.
REQ-027 abort in any state: go to IDLE, discard any partial nibble, no done pulse; FIFO contents and overflow are retained.
REQ-028 abort and start in the same cycle: abort wins.
REQ-029 rx_data and rx_valid come directly from FIFO registers; the FIFO pointers wrap modulo FIFO_DEPTH.
REQ-030 overflow clears only on reset, or on start accepted in IDLE.

Reset
REQ-031 Asserting sys_rst_n low immediately forces: state IDLE, FIFO empty, rx_valid 0, rx_data 0, busy 0, done 0, overflow 0, sio_oe 0, all counters 0.
REQ-032 Reset deassertion is synchronised internally; the first start is accepted on the second cycle after release.

Configuration
REQ-033 Macro SIO_NIBBLE_RX_SYNC_EN defined: sio_i passes through a two-flop synchroniser before capture; capture uses the synchronised value present when sample_en is high.
REQ-034 Macro SIO_NIBBLE_RX_SYNC_EN defined: the upstream sample_en generator must delay sample_en by 2 cycles.
REQ-035 Macro SIO_NIBBLE_RX_SYNC_EN undefined: sio_i is captured directly and there is no added latency.

Structure
REQ-036 Shared package sio_pkg holds: state enum, SIO_LANES=4, NIBBLE_W=4, BYTE_W=8.
REQ-037 The FIFO is one sub-module, sio_byte_fifo (parameter DEPTH, push/pop/full/empty), instantiated once.

Verification
REQ-038 dummy_cycles=2, byte_count=2, sio_i nibbles A,5,3,C on pulses 3-6, rx_ready=1 -> rx_data 0xA5 then 0x3C, one done pulse, overflow 0.
REQ-039 FIFO_DEPTH=4, rx_ready=0, byte_count=5 -> 4 bytes held, fifth byte dropped, overflow=1, done pulses once.
REQ-040 byte_count=0 -> exactly 256 bytes delivered, then the state returns to IDLE.
REQ-041 abort after the first nibble of byte 1 -> IDLE, byte 0 still in FIFO, no done; a new start then works normally.
REQ-042 sys_rst_n low mid-RECV with 2 bytes queued -> rx_valid=0 and busy=0 immediately.
REQ-043 SIO_NIBBLE_RX_SYNC_EN defined, sample_en delayed by 2 cycles -> same bytes as REQ-038.
